// File: rtl/div_unit_if.sv
// Handshake bundle between the EX stage and the iterative divider.
interface div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] data;

  modport master (output start, op, data1, data2, flush, input busy, done, data);
  modport slave  (input start, op, data1, data2, flush, output busy, done, data);
endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle,
// with divide-by-zero and signed-overflow results produced without iterating.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t           state_r, state_nx_s;
  logic             is_rem_r, neg_q_r, neg_r_r;
  logic [WIDTH-1:0] rem_r, quo_r, dsr_r, data_r;
  logic [CNT_W-1:0] cnt_r;

  logic             signed_s, sign1_s, sign2_s, div_zero_s, ovf_s, special_s, accept_s;
  logic [WIDTH-1:0] mag1_s, mag2_s, special_data_s;
  logic [WIDTH:0]   rem_sh_s, diff_s;
  logic             ge_s;
  logic [WIDTH-1:0] rem_nx_s, quo_nx_s, result_s;
  logic             busy_s, done_s;

  assign signed_s   = ~bus.op[0];
  assign sign1_s    = bus.data1[WIDTH-1] & signed_s;
  assign sign2_s    = bus.data2[WIDTH-1] & signed_s;
  assign mag1_s     = sign1_s ? (ZERO - bus.data1) : bus.data1;
  assign mag2_s     = sign2_s ? (ZERO - bus.data2) : bus.data2;
  assign div_zero_s = (bus.data2 == ZERO);
  assign ovf_s      = signed_s & (bus.data1 == MIN_VAL) & (bus.data2 == ONES);
  assign special_s  = div_zero_s | ovf_s;
  assign accept_s   = (state_r == IDLE) & bus.start & ~bus.flush;

  // Special-case result: divisor zero gives all-ones / raw dividend, overflow gives MIN / 0.
  always_comb begin
    special_data_s = ZERO;
    if (bus.op[1]) begin
      special_data_s = div_zero_s ? bus.data1 : ZERO;
    end else begin
      special_data_s = div_zero_s ? ONES : MIN_VAL;
    end
  end

  // The partial remainder needs one extra bit: shifting can exceed WIDTH bits for large divisors.
  assign rem_sh_s = {rem_r, quo_r[WIDTH-1]};
  assign diff_s   = rem_sh_s - {1'b0, dsr_r};
  assign ge_s     = ~diff_s[WIDTH];
  assign rem_nx_s = ge_s ? diff_s[WIDTH-1:0] : rem_sh_s[WIDTH-1:0];
  assign quo_nx_s = {quo_r[WIDTH-2:0], ge_s};

  // Sign-corrected final result from the last iteration step.
  always_comb begin
    result_s = ZERO;
    if (is_rem_r) begin
      result_s = neg_r_r ? (ZERO - rem_nx_s) : rem_nx_s;
    end else begin
      result_s = neg_q_r ? (ZERO - quo_nx_s) : quo_nx_s;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; flush aborts any active operation.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nx_s = special_s ? DONE : CALC;
        end else begin
          state_nx_s = IDLE;
        end
      end
      CALC: begin
        if (bus.flush) begin
          state_nx_s = IDLE;
        end else if (cnt_r == LAST_CNT) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = CALC;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Datapath: operand latch on accept, one restoring step per CALC cycle, result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_rem_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      rem_r    <= ZERO;
      quo_r    <= ZERO;
      dsr_r    <= ZERO;
      cnt_r    <= {CNT_W{1'b0}};
      data_r   <= ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            is_rem_r <= bus.op[1];
            neg_q_r  <= sign1_s ^ sign2_s;
            neg_r_r  <= sign1_s;
            rem_r    <= ZERO;
            quo_r    <= mag1_s;
            dsr_r    <= mag2_s;
            cnt_r    <= {CNT_W{1'b0}};
            if (special_s) begin
              data_r <= special_data_s;
            end
          end
        end
        CALC: begin
          if (!bus.flush) begin
            rem_r <= rem_nx_s;
            quo_r <= quo_nx_s;
            cnt_r <= cnt_r + CNT_ONE;
            if (cnt_r == LAST_CNT) begin
              data_r <= result_s;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode; a flush in the DONE cycle suppresses the pulse.
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    if (state_r != IDLE) begin
      busy_s = 1'b1;
    end else begin
      busy_s = 1'b0;
    end
    if ((state_r == DONE) && !bus.flush) begin
      done_s = 1'b1;
    end else begin
      done_s = 1'b0;
    end
  end

  assign bus.busy = busy_s;
  assign bus.done = done_s;
  assign bus.data = data_r;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, random ops against an
// arithmetic reference model, and hand-written handshake/flush/reset sequences.
module tb_div_unit;

  localparam int W = 32;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  div_unit_if #(.WIDTH(W)) bus ();

  div_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  // Reference: plain SV arithmetic plus the two architected special cases.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (!op[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return 33;
  endfunction

  // Issue one operation; latency counts cycles from the start cycle to the done cycle.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.data1 = a;
    bus.data2 = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 2'($urandom);
    bus.data1 = $urandom;
    bus.data2 = $urandom;
    lat = 1;
    while (!bus.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = bus.data;
  endtask

  vec_t        vecs[$];
  logic [31:0] res, a, b, prior;
  logic [1:0]  op;
  int          lat, done_seen;

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.data1 = 32'd0;
    bus.data2 = 32'd0;
    bus.flush = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_data", bus.data, 32'd0);
    rst = 1'b0;

    vecs.push_back('{2'b01, 32'd100,        32'd7,          32'd14,         33});
    vecs.push_back('{2'b11, 32'd100,        32'd7,          32'd2,          33});
    vecs.push_back('{2'b00, -32'sd100,      32'd7,          32'hFFFF_FFF2,  33});
    vecs.push_back('{2'b10, -32'sd100,      32'd7,          32'hFFFF_FFFE,  33});
    vecs.push_back('{2'b10, 32'd100,        -32'sd7,        32'd2,          33});
    vecs.push_back('{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  1});
    vecs.push_back('{2'b10, 32'd5,          32'd0,          32'd5,          1});
    vecs.push_back('{2'b00, -32'sd5,        32'd0,          32'hFFFF_FFFF,  1});
    vecs.push_back('{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1});
    vecs.push_back('{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1});
    vecs.push_back('{2'b01, 32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'd0,          33});
    vecs.push_back('{2'b11, 32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  33});
    vecs.push_back('{2'b00, 32'd7,          -32'sd2,        32'hFFFF_FFFD,  33});
    vecs.push_back('{2'b10, 32'd7,          -32'sd2,        32'd1,          33});
    vecs.push_back('{2'b00, 32'h8000_0000,  32'd1,          32'h8000_0000,  33});

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      check($sformatf("vec%0d_data", i), res, vecs[i].exp_res);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
    end

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a  = $urandom;
      case (i % 4)
        0:       b = 32'($urandom_range(0, 15));
        1:       b = -32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      if (i % 10 == 3) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      do_op(op, a, b, res, lat);
      check($sformatf("rnd%0d_op%0d_%08h_%08h", i, op, a, b), res, ref_div(op, a, b));
      check($sformatf("rnd%0d_lat", i), 32'(lat), 32'(ref_lat(op, a, b)));
    end

    // A start pulse while busy is ignored; the first result is unaffected.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.data1 = 32'd100; bus.data2 = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 100) begin
      if (lat == 10) begin
        bus.start = 1'b1; bus.op = 2'b11; bus.data1 = 32'd1000; bus.data2 = 32'd3;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    check("ignored_start_data", bus.data, 32'd14);
    check("ignored_start_lat", 32'(lat), 32'd33);
    check("busy_in_done", {31'd0, bus.busy}, 32'd1);

    // Back-to-back: accepted in the cycle right after DONE.
    do_op(2'b01, 32'd1000, 32'd3, res, lat);
    check("b2b_data", res, 32'd333);
    check("b2b_lat", 32'(lat), 32'd33);
    prior = res;

    // Flush during CALC: return to IDLE, no done pulse, data held.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.data1 = 32'd50; bus.data2 = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    done_seen = 0;
    for (int c = 1; c < 15; c++) begin
      if (bus.done) done_seen++;
      @(negedge clk);
    end
    bus.flush = 1'b1;
    #1;
    check("flush_calc_done_low", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_calc_idle", {31'd0, bus.busy}, 32'd0);
    for (int c = 0; c < 40; c++) begin
      if (bus.done) done_seen++;
      @(negedge clk);
    end
    check("flush_no_done", 32'(done_seen), 32'd0);
    check("flush_data_kept", bus.data, prior);
    do_op(2'b01, 32'd50, 32'd5, res, lat);
    check("after_flush_data", res, 32'd10);
    check("after_flush_lat", 32'(lat), 32'd33);

    // Flush in the DONE cycle masks the pulse.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.data1 = 32'd5; bus.data2 = 32'd0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b1;
    #1;
    check("flush_done_busy", {31'd0, bus.busy}, 32'd1);
    check("flush_done_masked", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_done_idle", {31'd0, bus.busy}, 32'd0);

    // Flush together with start in IDLE: nothing is accepted.
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b01; bus.data1 = 32'd9; bus.data2 = 32'd3;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    check("flush_start_idle", {31'd0, bus.busy}, 32'd0);

    // Asynchronous reset in the middle of CALC clears outputs immediately.
    do_op(2'b01, 32'd81, 32'd9, res, lat);
    check("pre_reset_data", res, 32'd9);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.data1 = 32'd100; bus.data2 = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("async_rst_done", {31'd0, bus.done}, 32'd0);
    check("async_rst_data", bus.data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.done || bus.busy) done_seen++;
      @(negedge clk);
    end
    check("no_done_after_rst", 32'(done_seen), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
